// File: rtl/fifo_pkg.sv
// rtl/fifo_pkg.sv - shared types and constants for the FIFO serial drain engine
package fifo_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_POP,
    ST_LOAD,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } tx_state_t;

  localparam int WCNT_W = 16;

  localparam int PARITY_NONE = 0;
  localparam int PARITY_EVEN = 1;

endpackage

// File: rtl/fifo_serial_tx_bit_timer.sv
// rtl/fifo_serial_tx_bit_timer.sv - per-bit cycle counter for the serial framer
module bit_timer #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic rd_clk,
  input  logic rstrn,
  input  logic clear,
  output logic bit_done
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign bit_done = (cnt_q == LAST);

  // Wrapping on bit_done keeps consecutive DATA bits aligned without a state change.
  always_comb begin
    cnt_d = cnt_q + CW'(1);
    if (clear || bit_done) cnt_d = '0;
  end

  always_ff @(posedge rd_clk or negedge rstrn) begin
    if (!rstrn) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/fifo_serial_tx.sv
// rtl/fifo_serial_tx.sv - pops FIFO words and shifts them out LSB-first on a UART-style line
module fifo_serial_tx
  import fifo_pkg::*;
#(
  parameter int DWIDTH       = 32,
  parameter int CLKS_PER_BIT = 16,
  parameter int PARITY_EN    = 0
) (
  input  logic              rd_clk,
  input  logic              rstrn,
  input  logic              enable,
  input  logic              empty,
  input  logic [DWIDTH-1:0] fifo_dout,
  output logic              rd_en,
  output logic              tx,
  output logic              busy,
  output logic [WCNT_W-1:0] words_sent
);

  localparam int IW = (DWIDTH > 1) ? $clog2(DWIDTH) : 1;
  localparam logic [IW-1:0] LAST_BIT = IW'(DWIDTH - 1);

  tx_state_t         state_q, state_d;
  logic [DWIDTH-1:0] shreg_q, shreg_d;
  logic [IW-1:0]     bit_idx_q, bit_idx_d;
  logic              parity_q, parity_d;
  logic [WCNT_W-1:0] words_sent_q, words_sent_d;
  logic              rd_en_q;
  logic              bit_done;
  logic              timer_clear;

  // Restart the bit period whenever the FSM moves to a different state.
  assign timer_clear = (state_d != state_q);

  bit_timer #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_bit_timer (
    .rd_clk  (rd_clk),
    .rstrn   (rstrn),
    .clear   (timer_clear),
    .bit_done(bit_done)
  );

  always_comb begin
    state_d      = state_q;
    shreg_d      = shreg_q;
    bit_idx_d    = bit_idx_q;
    parity_d     = parity_q;
    words_sent_d = words_sent_q;
    tx           = 1'b1;
    case (state_q)
      ST_IDLE: begin
        if (enable && !empty) state_d = ST_POP;
      end
      ST_POP: begin
        state_d = ST_LOAD;
      end
      ST_LOAD: begin
        shreg_d   = fifo_dout;
        parity_d  = ^fifo_dout;
        bit_idx_d = '0;
        state_d   = ST_START;
      end
      ST_START: begin
        tx = 1'b0;
        if (bit_done) state_d = ST_DATA;
      end
      ST_DATA: begin
        tx = shreg_q[0];
        if (bit_done) begin
          if (bit_idx_q == LAST_BIT) begin
            state_d = (PARITY_EN == PARITY_EVEN) ? ST_PARITY : ST_STOP;
          end else begin
            shreg_d   = shreg_q >> 1;
            bit_idx_d = bit_idx_q + IW'(1);
          end
        end
      end
      ST_PARITY: begin
        tx = parity_q;
        if (bit_done) state_d = ST_STOP;
      end
      ST_STOP: begin
        if (bit_done) begin
          words_sent_d = words_sent_q + WCNT_W'(1);
          state_d      = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge rd_clk or negedge rstrn) begin
    if (!rstrn) begin
      state_q      <= ST_IDLE;
      shreg_q      <= '0;
      bit_idx_q    <= '0;
      parity_q     <= 1'b0;
      words_sent_q <= '0;
      rd_en_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      shreg_q      <= shreg_d;
      bit_idx_q    <= bit_idx_d;
      parity_q     <= parity_d;
      words_sent_q <= words_sent_d;
      rd_en_q      <= (state_d == ST_POP);
    end
  end

  assign rd_en      = rd_en_q;
  assign busy       = (state_q != ST_IDLE);
  assign words_sent = words_sent_q;

endmodule

// File: tb/tb_fifo_serial_tx.sv
// tb/tb_fifo_serial_tx.sv - directed self-checking bench for fifo_serial_tx
module tb_fifo_serial_tx;

  logic        rd_clk = 1'b0;
  logic        rstrn  = 1'b0;
  logic        enable_a = 1'b0, enable_p = 1'b0;
  logic        empty_a, empty_p;
  logic [7:0]  dout_a = 8'h00, dout_p = 8'h00;
  logic        rd_en_a, rd_en_p, tx_a, tx_p, busy_a, busy_p;
  logic [15:0] ws_a, ws_p;

  int tests  = 0;
  int failed = 0;

  logic [7:0] mem_a [16];
  logic [7:0] mem_p [16];
  logic [3:0] wp_a = 4'd0, rp_a = 4'd0, wp_p = 4'd0, rp_p = 4'd0;
  int pops_a = 0, pops_p = 0, underflow_a = 0, underflow_p = 0;

  always #5 rd_clk = ~rd_clk;

  fifo_serial_tx #(.DWIDTH(8), .CLKS_PER_BIT(4), .PARITY_EN(0)) u_dut_a (
    .rd_clk(rd_clk), .rstrn(rstrn), .enable(enable_a), .empty(empty_a),
    .fifo_dout(dout_a), .rd_en(rd_en_a), .tx(tx_a), .busy(busy_a), .words_sent(ws_a)
  );

  fifo_serial_tx #(.DWIDTH(8), .CLKS_PER_BIT(4), .PARITY_EN(1)) u_dut_p (
    .rd_clk(rd_clk), .rstrn(rstrn), .enable(enable_p), .empty(empty_p),
    .fifo_dout(dout_p), .rd_en(rd_en_p), .tx(tx_p), .busy(busy_p), .words_sent(ws_p)
  );

  // FIFO models with registered read data.
  assign empty_a = (wp_a == rp_a);
  assign empty_p = (wp_p == rp_p);

  always @(posedge rd_clk) begin
    if (rd_en_a) begin
      if (empty_a) underflow_a <= underflow_a + 1;
      dout_a <= mem_a[rp_a];
      rp_a   <= rp_a + 4'd1;
      pops_a <= pops_a + 1;
    end
    if (rd_en_p) begin
      if (empty_p) underflow_p <= underflow_p + 1;
      dout_p <= mem_p[rp_p];
      rp_p   <= rp_p + 4'd1;
      pops_p <= pops_p + 1;
    end
  end

  task automatic push_a(input logic [7:0] w);
    mem_a[wp_a] = w;
    wp_a = wp_a + 4'd1;
  endtask

  task automatic push_p(input logic [7:0] w);
    mem_p[wp_p] = w;
    wp_p = wp_p + 4'd1;
  endtask

  function automatic logic tx_of(input bit sel);
    return sel ? tx_p : tx_a;
  endfunction

  task automatic do_reset();
    @(negedge rd_clk);
    rstrn = 1'b0;
    @(negedge rd_clk);
    @(negedge rd_clk);
    rstrn = 1'b1;
  endtask

  // Waits for the start bit, then checks every cycle of every bit; returns at the first post-STOP negedge.
  task automatic check_frame(input bit sel, input logic [7:0] w, input int drop_at, input string nm);
    logic [10:0] bits;
    int n, nbits, bad;
    n = 0;
    while (tx_of(sel) !== 1'b0 && n < 200) begin
      @(negedge rd_clk);
      n++;
    end
    tests++;
    if (n >= 200) begin
      failed++;
      $display("FAIL %s start_timeout: tx=%b after %0d cycles, required 0", nm, tx_of(sel), n);
      return;
    end
    bits = '0;
    bits[8:1] = w;
    if (sel) begin
      bits[9]  = ^w;
      bits[10] = 1'b1;
      nbits    = 11;
    end else begin
      bits[9] = 1'b1;
      nbits   = 10;
    end
    for (int b = 0; b < nbits; b++) begin
      bad = 0;
      for (int c = 0; c < 4; c++) begin
        if (drop_at == b * 4 + c) enable_a = 1'b0;
        if (tx_of(sel) !== bits[b]) bad++;
        @(negedge rd_clk);
      end
      tests++;
      if (bad != 0) begin
        failed++;
        $display("FAIL %s frame_bit%0d: %0d of 4 cycles wrong, required tx=%b", nm, b, bad, bits[b]);
      end
    end
  endtask

  task automatic test_reset();
    int bad_a, bad_p;
    enable_a = 1'b1;
    enable_p = 1'b1;
    rstrn = 1'b0;
    @(negedge rd_clk);
    tests++; if (tx_a !== 1'b1)    begin failed++; $display("FAIL reset_tx: got %b, required 1", tx_a); end
    tests++; if (rd_en_a !== 1'b0) begin failed++; $display("FAIL reset_rd_en: got %b, required 0", rd_en_a); end
    tests++; if (busy_a !== 1'b0)  begin failed++; $display("FAIL reset_busy: got %b, required 0", busy_a); end
    tests++; if (ws_a !== 16'h0)   begin failed++; $display("FAIL reset_words: got %h, required 0000", ws_a); end
    rstrn = 1'b1;
    bad_a = 0;
    bad_p = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge rd_clk);
      if (tx_a !== 1'b1 || rd_en_a !== 1'b0 || busy_a !== 1'b0 || ws_a !== 16'h0) bad_a++;
      if (tx_p !== 1'b1 || rd_en_p !== 1'b0 || busy_p !== 1'b0 || ws_p !== 16'h0) bad_p++;
    end
    tests++; if (bad_a != 0) begin failed++; $display("FAIL empty_idle_a: %0d bad cycles, required 0", bad_a); end
    tests++; if (bad_p != 0) begin failed++; $display("FAIL empty_idle_p: %0d bad cycles, required 0", bad_p); end
  endtask

  task automatic test_single();
    int p0;
    enable_a = 1'b1;
    do_reset();
    p0 = pops_a;
    @(negedge rd_clk);
    push_a(8'hA5);
    @(negedge rd_clk);
    tests++; if (rd_en_a !== 1'b1) begin failed++; $display("FAIL single_rd_en_cycle1: got %b, required 1", rd_en_a); end
    @(negedge rd_clk);
    tests++; if (rd_en_a !== 1'b0 || tx_a !== 1'b1) begin
      failed++; $display("FAIL single_load_cycle2: rd_en=%b tx=%b, required 0/1", rd_en_a, tx_a);
    end
    @(negedge rd_clk);
    tests++; if (tx_a !== 1'b0) begin failed++; $display("FAIL single_start_cycle3: got %b, required 0", tx_a); end
    check_frame(1'b0, 8'hA5, -1, "single");
    tests++; if (ws_a !== 16'd1)       begin failed++; $display("FAIL single_words: got %0d, required 1", ws_a); end
    tests++; if (busy_a !== 1'b0)      begin failed++; $display("FAIL single_busy_end: got %b, required 0", busy_a); end
    tests++; if (pops_a - p0 != 1)     begin failed++; $display("FAIL single_pops: got %0d, required 1", pops_a - p0); end
  endtask

  task automatic test_parity_b2b();
    int p0, gap_bad;
    enable_p = 1'b1;
    do_reset();
    p0 = pops_p;
    @(negedge rd_clk);
    push_p(8'hA5);
    push_p(8'h01);
    check_frame(1'b1, 8'hA5, -1, "par_w0");
    gap_bad = 0;
    for (int g = 0; g < 3; g++) begin
      if (tx_p !== 1'b1) gap_bad++;
      @(negedge rd_clk);
    end
    tests++; if (gap_bad != 0) begin failed++; $display("FAIL par_gap_high: %0d low cycles, required 0", gap_bad); end
    tests++; if (tx_p !== 1'b0) begin failed++; $display("FAIL par_gap_len: tx=%b after 3 idle cycles, required 0", tx_p); end
    check_frame(1'b1, 8'h01, -1, "par_w1");
    tests++; if (ws_p !== 16'd2)   begin failed++; $display("FAIL par_words: got %0d, required 2", ws_p); end
    tests++; if (pops_p - p0 != 2) begin failed++; $display("FAIL par_pops: got %0d, required 2", pops_p - p0); end
  endtask

  task automatic test_enable_drop();
    int p0;
    logic [3:0] left;
    enable_a = 1'b1;
    do_reset();
    p0 = pops_a;
    @(negedge rd_clk);
    push_a(8'h11);
    push_a(8'h22);
    push_a(8'h33);
    push_a(8'h44);
    check_frame(1'b0, 8'h11, 12, "en_drop");
    repeat (20) @(negedge rd_clk);
    left = wp_a - rp_a;
    tests++; if (pops_a - p0 != 1) begin failed++; $display("FAIL en_drop_pops: got %0d, required 1", pops_a - p0); end
    tests++; if (left !== 4'd3)    begin failed++; $display("FAIL en_drop_left: got %0d, required 3", left); end
    tests++; if (ws_a !== 16'd1)   begin failed++; $display("FAIL en_drop_words: got %0d, required 1", ws_a); end
    tests++; if (busy_a !== 1'b0)  begin failed++; $display("FAIL en_drop_busy: got %b, required 0", busy_a); end
    tests++; if (underflow_a != 0) begin failed++; $display("FAIL underflow_a: got %0d, required 0", underflow_a); end
    wp_a = rp_a;
  endtask

  task automatic test_async_reset();
    int p0, n;
    enable_a = 1'b0;
    do_reset();
    p0 = pops_a;
    @(negedge rd_clk);
    push_a(8'h3C);
    push_a(8'h96);
    enable_a = 1'b1;
    n = 0;
    while (tx_a !== 1'b0 && n < 50) begin
      @(negedge rd_clk);
      n++;
    end
    repeat (10) @(negedge rd_clk);
    tests++; if (tx_a !== 1'b0) begin failed++; $display("FAIL arst_pre_tx: got %b, required 0", tx_a); end
    #2;
    rstrn = 1'b0;
    #1;
    tests++; if (tx_a !== 1'b1)    begin failed++; $display("FAIL arst_tx: got %b, required 1", tx_a); end
    tests++; if (rd_en_a !== 1'b0) begin failed++; $display("FAIL arst_rd_en: got %b, required 0", rd_en_a); end
    tests++; if (busy_a !== 1'b0)  begin failed++; $display("FAIL arst_busy: got %b, required 0", busy_a); end
    @(negedge rd_clk);
    rstrn = 1'b1;
    check_frame(1'b0, 8'h96, -1, "arst_next");
    tests++; if (ws_a !== 16'd1)   begin failed++; $display("FAIL arst_words: got %0d, required 1", ws_a); end
    tests++; if (pops_a - p0 != 2) begin failed++; $display("FAIL arst_pops: got %0d, required 2", pops_a - p0); end
  endtask

  task automatic test_wrap();
    enable_a = 1'b0;
    do_reset();
    @(negedge rd_clk);
    #1;
    force u_dut_a.words_sent_q = 16'hFFFF;
    #1;
    release u_dut_a.words_sent_q;
    #1;
    tests++; if (ws_a !== 16'hFFFF) begin failed++; $display("FAIL wrap_preload: got %h, required ffff", ws_a); end
    @(negedge rd_clk);
    push_a(8'h5A);
    enable_a = 1'b1;
    check_frame(1'b0, 8'h5A, -1, "wrap");
    tests++; if (ws_a !== 16'h0000) begin failed++; $display("FAIL wrap_words: got %h, required 0000", ws_a); end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_single();
    test_parity_b2b();
    test_enable_drop();
    test_async_reset();
    test_wrap();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/fifo_serial_tx.md
# fifo_serial_tx

Read-side drain engine for the team's FIFOs. It sits in the read clock domain on the FIFO read port, pops one word at a time whenever the FIFO is non-empty and transmission is enabled, and shifts each word out LSB-first on a single-wire, UART-style serial line. The framing is start bit, DWIDTH data bits, optional even-parity bit, then stop bit. It is the consumer counterpart to the FIFO writer: the write side fills the FIFO, and this block empties it onto a link.

## Interface
- DWIDTH, 32, word width; must match the FIFO's DWIDTH.
- CLKS_PER_BIT, 16, rd_clk cycles per serial bit; must be ≥ 2.
- PARITY_EN, 0, 1 inserts an even-parity bit between the data and stop bits.
- rd_clk  input  1  the single clock; all state is updated on its rising edge.
- rstrn  input  1  asynchronous, active-low reset.
- enable  input  1  permits new pops; sampled only in IDLE.
- empty  input  1  FIFO empty flag.
- fifo_dout  input  DWIDTH  FIFO registered read data; valid in the cycle after a pop edge.
- rd_en  output  1  FIFO read strobe; registered, one cycle high per word.
- tx  output  1  serial line; idles high.
- busy  output  1  high in every state except IDLE.
- words_sent  output  16  count of completed frames; wraps from 0xFFFF to 0.

## Operation
- States: IDLE, POP, LOAD, START, DATA, PARITY, STOP.
- IDLE: tx=1. If enable & !empty, go to POP; otherwise stay in IDLE.
- POP: rd_en=1 for exactly this one cycle. The FIFO pops on the edge that ends POP. Always go to LOAD.
- LOAD: capture fifo_dout into the shift register on the edge that ends LOAD. Compute parity as the XOR of the captured word. Go to START.
- START: tx=0 for CLKS_PER_BIT cycles, then go to DATA.
- DATA: tx = shreg[0].
  - Each bit is held for CLKS_PER_BIT cycles, then the register shifts right.
  - A bit index counts 0..DWIDTH-1.
  - After bit DWIDTH-1, go to PARITY if PARITY_EN, else to STOP.
- PARITY: tx = parity bit for CLKS_PER_BIT cycles, then go to STOP.
- STOP: tx=1 for CLKS_PER_BIT cycles. On the final cycle, increment words_sent and go to IDLE.
- Bit timer:
  - Counter width is $clog2(CLKS_PER_BIT).
  - It reloads to 0 on every state entry.
  - It asserts bit_done when count = CLKS_PER_BIT-1.
- Bit index width is $clog2(DWIDTH).
- words_sent addition is modulo 2^16.
- enable deasserted mid-frame: the current frame completes; no further pop occurs.
- empty is ignored outside IDLE. If the FIFO goes empty mid-frame, the frame still completes.
- Back-to-back words: three idle-high cycles (IDLE, POP, LOAD) separate one STOP from the next START.
- The block never asserts rd_en while empty=1, so no underflow is possible.
- Reset mid-frame takes effect immediately (asynchronous):
  - tx=1, rd_en=0, state IDLE.
  - The partial frame is abandoned.
  - A word already popped is lost; this loss is documented and accepted.

## Timing
- Reset values: tx=1, rd_en=0, busy=0, words_sent=0, state IDLE, shift register 0.
- Let cycle 0 be the first IDLE cycle with enable & !empty:
  - rd_en is high in cycle 1.
  - tx falls in cycle 3.
  - Data bit 0 starts at cycle 3+CLKS_PER_BIT.
- Frame length is (2 + DWIDTH + PARITY_EN)·CLKS_PER_BIT cycles, measured from the START edge to the end of STOP.
- words_sent updates on the edge that ends STOP. busy falls on the same edge.
- Throughput: one word per (2+DWIDTH+PARITY_EN)·CLKS_PER_BIT + 3 cycles.

## Structure
- Shared package fifo_pkg holds:
  - the state enum typedef tx_state_t;
  - the localparam for the words_sent width (16);
  - the parity-mode constants.
- One sub-module, bit_timer, provides the bit counter:
  - inputs: clear, CLKS_PER_BIT parameter;
  - output: bit_done.
- The top level holds the FSM, the shift register, the bit index, parity and words_sent.

## Test plan
- Reset release with empty=1, enable=1 → tx stays 1, rd_en never asserts, busy=0, words_sent=0 for 100 cycles.
- DWIDTH=8, CLKS_PER_BIT=4, one word 0xA5 → exactly one rd_en pulse; tx bits 0,1,0,1,0,0,1,0,1,1, each 4 cycles; words_sent=1 afterwards.
- PARITY_EN=1, words 0xA5 then 0x01 → parity bits 0 then 1; the frames are 44 cycles each, separated by exactly 3 idle-high cycles.
- Four queued words, enable dropped during the first frame's DATA state → the first frame completes, only one rd_en pulse occurs, the FIFO retains 3 words, and words_sent=1.
- Async reset asserted mid-DATA → tx=1 and rd_en=0 immediately; after release with the FIFO non-empty, the next word is transmitted correctly.
- words_sent preloaded via force to 0xFFFF, then one frame → words_sent=0x0000.
